// File: rtl/z80_uart_rxbuf_if.sv
// Z80 slave-bus signals for the UART receive buffer: chip select, strobes and
// write data from the CPU side, read data and the active-low wait back to it.
interface z80_uart_rxbuf_if;
    logic       ena;
    logic       addr;
    logic       rdn;
    logic       wrn;
    logic [7:0] dmaster;
    logic [7:0] dslave;
    logic       mwait;

    modport master (output ena, addr, rdn, wrn, dmaster, input dslave, mwait);
    modport slave  (input ena, addr, rdn, wrn, dmaster, output dslave, mwait);
endinterface

// File: rtl/z80_uart_rxbuf.sv
// Receive FIFO between uart_rx and the Z80 bus: DATA/STATUS-CTRL register pair,
// mwait stall on empty DATA reads, sticky overrun and a registered interrupt.
module z80_uart_rxbuf #(
    parameter int DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    z80_uart_rxbuf_if.slave   bus,
    input  logic              rx_dv,
    input  logic [7:0]        rx_byte,
    output logic              irq_n
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [7:0]    fifo_mem [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overrun_q, overrun_d;
    logic          ie_q, ie_d;
    logic          served_q, served_d;
    logic [7:0]    dslave_q, dslave_d;
    logic          irq_n_q, irq_n_d;

    logic access, new_access, bus_idle;
    logic rd_data, rd_stat, wr_ctrl, wr_data;
    logic empty, full;
    logic pop, push, overrun_evt, stat_rd, ctrl_wr, data_wr, complete;
    logic unused_dmaster;

    assign access     = bus.ena & (~bus.rdn | ~bus.wrn);
    assign new_access = access & ~served_q;
    assign bus_idle   = ~bus.ena | (bus.rdn & bus.wrn);
    assign rd_data    = bus.ena & ~bus.rdn & ~bus.addr;
    assign rd_stat    = bus.ena & ~bus.rdn & bus.addr;
    assign wr_ctrl    = bus.ena & ~bus.wrn & bus.addr;
    assign wr_data    = bus.ena & ~bus.wrn & ~bus.addr;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_COUNT);

    // Pops only see bytes already counted, so a push is visible one cycle later.
    assign pop         = rd_data & ~served_q & ~empty;
    assign stat_rd     = rd_stat & ~served_q;
    assign ctrl_wr     = wr_ctrl & ~served_q;
    assign data_wr     = wr_data & ~served_q;
    assign push        = rx_dv & (~full | pop);
    assign overrun_evt = rx_dv & full & ~pop;
    assign complete    = pop | stat_rd | ctrl_wr | data_wr;

    assign unused_dmaster = ^{bus.dmaster[7:4], bus.dmaster[1:0]};

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        ie_d      = ie_q;
        served_d  = served_q;
        dslave_d  = dslave_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            dslave_d = fifo_mem[rd_ptr_q];
        end else if (stat_rd) begin
            dslave_d = {4'b0000, ie_q, overrun_q, full, ~empty};
        end

        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as a clear leaves overrun set.
        if (ctrl_wr) begin
            ie_d = bus.dmaster[3];
            if (bus.dmaster[2]) begin
                overrun_d = 1'b0;
            end
        end
        if (overrun_evt) begin
            overrun_d = 1'b1;
        end

        if (bus_idle) begin
            served_d = 1'b0;
        end else if (complete) begin
            served_d = 1'b1;
        end

        irq_n_d = ~(ie_q & (~empty | overrun_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            ie_q      <= 1'b0;
            served_q  <= 1'b0;
            dslave_q  <= 8'h00;
            irq_n_q   <= 1'b1;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            ie_q      <= ie_d;
            served_q  <= served_d;
            dslave_q  <= dslave_d;
            irq_n_q   <= irq_n_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= rx_byte;
        end
    end

    assign bus.dslave = dslave_q;
    assign bus.mwait  = ~rst_n | ~new_access;
    assign irq_n      = irq_n_q;
endmodule

// File: tb/tb_z80_uart_rxbuf.sv
// Randomised bench for z80_uart_rxbuf against a queue-based model of the
// receive buffer's register, wait and interrupt behaviour.
module tb_z80_uart_rxbuf;
    localparam int DEPTH = 16;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b1;
    logic       rx_dv   = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       irq_n;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mq[$];
    logic       m_ovr = 1'b0;
    logic       m_ie  = 1'b0;

    z80_uart_rxbuf_if bus();

    z80_uart_rxbuf #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .rx_dv   (rx_dv),
        .rx_byte (rx_byte),
        .irq_n   (irq_n)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_status();
        return {4'b0000, m_ie, m_ovr, (mq.size() == DEPTH), (mq.size() != 0)};
    endfunction

    // Holds the strobe until mwait is released and at least strobe cycles have passed.
    task automatic bus_access(input logic is_wr, input logic a, input logic [7:0] wdata,
                              input int strobe, output logic [7:0] rdata, output int waits);
        int cyc;
        cyc   = 0;
        waits = 0;
        bus.ena     = 1'b1;
        bus.addr    = a;
        bus.dmaster = wdata;
        bus.rdn     = is_wr;
        bus.wrn     = ~is_wr;
        forever begin
            #1;
            if (bus.mwait === 1'b0) waits++;
            cyc++;
            if (bus.mwait === 1'b1 && cyc >= strobe) break;
            if (cyc > 400) begin
                checks++;
                failures++;
                $display("[TB] FAIL bus_timeout mwait=%b still low after %0d cycles, required release", bus.mwait, cyc);
                break;
            end
            @(negedge clk);
        end
        rdata = bus.dslave;
        @(negedge clk);
        bus.ena = 1'b0;
        bus.rdn = 1'b1;
        bus.wrn = 1'b1;
        @(negedge clk);
    endtask

    task automatic rx_push_at(input int delay, input logic [7:0] b);
        repeat (delay) @(negedge clk);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(negedge clk);
        rx_dv   = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        int w;
        #2 rst_n = 1'b0;
        @(negedge clk);
        bus.ena = 1'b1;
        bus.rdn = 1'b0;
        #1;
        checks++; if (bus.mwait !== 1'b1) begin failures++; $display("[TB] FAIL reset_mwait got %b exp 1", bus.mwait); end
        checks++; if (bus.dslave !== 8'h00) begin failures++; $display("[TB] FAIL reset_dslave got %h exp 00", bus.dslave); end
        checks++; if (irq_n !== 1'b1) begin failures++; $display("[TB] FAIL reset_irq_n got %b exp 1", irq_n); end
        bus.ena = 1'b0;
        bus.rdn = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_access(1'b0, 1'b1, 8'h00, 2, d, w);
        checks++; if (w !== 1) begin failures++; $display("[TB] FAIL reset_status_waits got %0d exp 1", w); end
        checks++; if (d !== exp_status()) begin failures++; $display("[TB] FAIL reset_status got %h exp %h", d, exp_status()); end
        checks++; if (irq_n !== 1'b1) begin failures++; $display("[TB] FAIL reset_status_irq got %b exp 1", irq_n); end
    endtask

    task automatic test_fifo_order();
        logic [7:0] d, e, last;
        logic [7:0] bytes[$];
        int w;
        last = 8'h00;
        for (int round = 0; round < 2; round++) begin
            bytes.delete();
            if (round == 0) begin
                bytes.push_back(8'h41); bytes.push_back(8'h42); bytes.push_back(8'h43);
            end else begin
                for (int i = 0; i < 5; i++) bytes.push_back(8'($urandom));
            end
            foreach (bytes[i]) begin
                rx_push_at(4, bytes[i]);
                mq.push_back(bytes[i]);
            end
            while (mq.size() != 0) begin
                bus_access(1'b0, 1'b0, 8'h00, 4, d, w);
                e = mq.pop_front();
                last = e;
                checks++; if (d !== e) begin failures++; $display("[TB] FAIL order_data got %h exp %h", d, e); end
                checks++; if (w !== 1) begin failures++; $display("[TB] FAIL order_waits got %0d exp 1", w); end
            end
        end
        repeat (3) @(negedge clk);
        checks++; if (bus.dslave !== last) begin failures++; $display("[TB] FAIL dslave_hold got %h exp %h", bus.dslave, last); end
        bus_access(1'b0, 1'b1, 8'h00, 2, d, w);
        checks++; if (d !== exp_status()) begin failures++; $display("[TB] FAIL order_status got %h exp %h", d, exp_status()); end
    endtask

    task automatic test_empty_wait();
        logic [7:0] d, b1, b2, e;
        int w;
        b1 = 8'h5A;
        b2 = 8'($urandom);
        fork
            bus_access(1'b0, 1'b0, 8'h00, 2, d, w);
            begin
                rx_push_at(10, b1);
                rx_push_at(0, b2);
            end
        join
        mq.push_back(b2);
        checks++; if (w !== 12) begin failures++; $display("[TB] FAIL empty_wait_cycles got %0d exp 12", w); end
        checks++; if (d !== b1) begin failures++; $display("[TB] FAIL empty_wait_data got %h exp %h", d, b1); end
        bus_access(1'b0, 1'b1, 8'h00, 2, d, w);
        checks++; if (d !== exp_status()) begin failures++; $display("[TB] FAIL single_pop_status got %h exp %h", d, exp_status()); end
        bus_access(1'b0, 1'b0, 8'h00, 3, d, w);
        e = mq.pop_front();
        checks++; if (d !== e) begin failures++; $display("[TB] FAIL empty_wait_second got %h exp %h", d, e); end
    endtask

    task automatic test_overrun();
        logic [7:0] d, e;
        int w;
        for (int i = 0; i < DEPTH; i++) begin
            rx_push_at(0, 8'(i));
            mq.push_back(8'(i));
        end
        rx_push_at(0, 8'hFF);
        m_ovr = 1'b1;
        bus_access(1'b0, 1'b1, 8'h00, 2, d, w);
        checks++; if (d !== 8'h07) begin failures++; $display("[TB] FAIL overrun_status got %h exp 07", d); end
        fork
            bus_access(1'b1, 1'b1, 8'h04, 2, d, w);
            rx_push_at(0, 8'hEE);
        join
        bus_access(1'b0, 1'b1, 8'h00, 2, d, w);
        checks++; if (d !== exp_status()) begin failures++; $display("[TB] FAIL overrun_beats_clear got %h exp %h", d, exp_status()); end
        while (mq.size() != 0) begin
            bus_access(1'b0, 1'b0, 8'h00, 2, d, w);
            e = mq.pop_front();
            checks++; if (d !== e) begin failures++; $display("[TB] FAIL overrun_drain got %h exp %h", d, e); end
        end
        bus_access(1'b0, 1'b1, 8'h00, 2, d, w);
        checks++; if (d !== 8'h04) begin failures++; $display("[TB] FAIL overrun_drained_status got %h exp 04", d); end
        bus_access(1'b1, 1'b1, 8'h04, 2, d, w);
        m_ovr = 1'b0;
        m_ie  = 1'b0;
        bus_access(1'b0, 1'b1, 8'h00, 2, d, w);
        checks++; if (d !== 8'h00) begin failures++; $display("[TB] FAIL overrun_cleared got %h exp 00", d); end
    endtask

    task automatic test_push_pop_same();
        logic [7:0] d, e, nb;
        int w;
        for (int i = 0; i < DEPTH; i++) begin
            nb = 8'($urandom);
            rx_push_at(0, nb);
            mq.push_back(nb);
        end
        nb = 8'($urandom);
        fork
            bus_access(1'b0, 1'b0, 8'h00, 3, d, w);
            rx_push_at(0, nb);
        join
        e = mq.pop_front();
        mq.push_back(nb);
        checks++; if (d !== e) begin failures++; $display("[TB] FAIL full_pushpop_data got %h exp %h", d, e); end
        bus_access(1'b0, 1'b1, 8'h00, 2, d, w);
        checks++; if (d !== 8'h03) begin failures++; $display("[TB] FAIL full_pushpop_status got %h exp 03", d); end
        while (mq.size() != 0) begin
            bus_access(1'b0, 1'b0, 8'h00, 2, d, w);
            e = mq.pop_front();
            checks++; if (d !== e) begin failures++; $display("[TB] FAIL full_pushpop_drain got %h exp %h", d, e); end
        end
    endtask

    task automatic test_irq();
        logic [7:0] d, e, b;
        int w;
        bus_access(1'b1, 1'b1, 8'h08, 2, d, w);
        m_ie = 1'b1;
        checks++; if (irq_n !== 1'b1) begin failures++; $display("[TB] FAIL irq_idle got %b exp 1", irq_n); end
        b = 8'($urandom);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(negedge clk);
        rx_dv = 1'b0;
        mq.push_back(b);
        checks++; if (irq_n !== 1'b1) begin failures++; $display("[TB] FAIL irq_latency1 got %b exp 1", irq_n); end
        @(negedge clk);
        checks++; if (irq_n !== 1'b0) begin failures++; $display("[TB] FAIL irq_latency2 got %b exp 0", irq_n); end
        bus_access(1'b0, 1'b1, 8'h00, 2, d, w);
        checks++; if (d !== 8'h09) begin failures++; $display("[TB] FAIL irq_status got %h exp 09", d); end
        bus_access(1'b0, 1'b0, 8'h00, 2, d, w);
        e = mq.pop_front();
        checks++; if (d !== e) begin failures++; $display("[TB] FAIL irq_data got %h exp %h", d, e); end
        checks++; if (irq_n !== 1'b1) begin failures++; $display("[TB] FAIL irq_drained got %b exp 1", irq_n); end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] d;
        int w;
        bus.ena  = 1'b1;
        bus.addr = 1'b0;
        bus.rdn  = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (bus.mwait !== 1'b0) begin failures++; $display("[TB] FAIL midread_stall got %b exp 0", bus.mwait); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.mwait !== 1'b1) begin failures++; $display("[TB] FAIL midread_reset_mwait got %b exp 1", bus.mwait); end
        checks++; if (bus.dslave !== 8'h00) begin failures++; $display("[TB] FAIL midread_reset_dslave got %h exp 00", bus.dslave); end
        bus.ena = 1'b0;
        bus.rdn = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        m_ovr = 1'b0;
        m_ie  = 1'b0;
        @(negedge clk);
        bus_access(1'b0, 1'b1, 8'h00, 2, d, w);
        checks++; if (d !== 8'h00) begin failures++; $display("[TB] FAIL midread_after_status got %h exp 00", d); end
    endtask

    task automatic test_random();
        logic [7:0] d, e, v, b;
        logic exp_irq;
        int w, op;
        for (int it = 0; it < 150; it++) begin
            op = $urandom_range(0, 9);
            if (op <= 4) begin
                b = 8'($urandom);
                rx_push_at(0, b);
                if (mq.size() < DEPTH) mq.push_back(b);
                else m_ovr = 1'b1;
            end else if (op <= 6 && mq.size() != 0) begin
                bus_access(1'b0, 1'b0, 8'h00, $urandom_range(1, 4), d, w);
                e = mq.pop_front();
                checks++; if (d !== e) begin failures++; $display("[TB] FAIL rand_data it=%0d got %h exp %h", it, d, e); end
                checks++; if (w !== 1) begin failures++; $display("[TB] FAIL rand_data_waits it=%0d got %0d exp 1", it, w); end
            end else if (op <= 7) begin
                e = exp_status();
                bus_access(1'b0, 1'b1, 8'h00, $urandom_range(1, 4), d, w);
                checks++; if (d !== e) begin failures++; $display("[TB] FAIL rand_status it=%0d got %h exp %h", it, d, e); end
            end else begin
                v = 8'($urandom);
                bus_access(1'b1, (op == 8), v, $urandom_range(1, 3), d, w);
                if (op == 8) begin
                    m_ie = v[3];
                    if (v[2]) m_ovr = 1'b0;
                end
                checks++; if (w !== 1) begin failures++; $display("[TB] FAIL rand_write_waits it=%0d got %0d exp 1", it, w); end
            end
            @(negedge clk);
            exp_irq = ~(m_ie & ((mq.size() != 0) | m_ovr));
            checks++; if (irq_n !== exp_irq) begin failures++; $display("[TB] FAIL rand_irq it=%0d got %b exp %b", it, irq_n, exp_irq); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.ena     = 1'b0;
        bus.addr    = 1'b0;
        bus.rdn     = 1'b1;
        bus.wrn     = 1'b1;
        bus.dmaster = 8'h00;
        test_reset();
        test_fifo_order();
        test_empty_wait();
        test_overrun();
        test_push_pop_same();
        test_irq();
        test_reset_mid_read();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
